// File: rtl/voice_bank_if.sv
// Groups the voice bank control, note-load and status signals into one bundle.
// Latency: none (wiring only).
// Backpressure: none; the done levels tell the master which voices can take a note.
interface voice_bank_if;
    logic       play;
    logic       beat;
    logic       new_note_one;
    logic       new_note_two;
    logic       new_note_three;
    logic [5:0] note_one;
    logic [5:0] note_two;
    logic [5:0] note_three;
    logic [5:0] duration_one;
    logic [5:0] duration_two;
    logic [5:0] duration_three;
    logic       note_one_done;
    logic       note_two_done;
    logic       note_three_done;
    logic [5:0] voice_note_one;
    logic [5:0] voice_note_two;
    logic [5:0] voice_note_three;
    logic       all_idle;
    logic       load_error;

    modport master (
        output play, beat,
        output new_note_one, new_note_two, new_note_three,
        output note_one, note_two, note_three,
        output duration_one, duration_two, duration_three,
        input  note_one_done, note_two_done, note_three_done,
        input  voice_note_one, voice_note_two, voice_note_three,
        input  all_idle, load_error
    );

    modport slave (
        input  play, beat,
        input  new_note_one, new_note_two, new_note_three,
        input  note_one, note_two, note_three,
        input  duration_one, duration_two, duration_three,
        output note_one_done, note_two_done, note_three_done,
        output voice_note_one, voice_note_two, voice_note_three,
        output all_idle, load_error
    );
endinterface

// File: rtl/voice_bank.sv
// Three independent note-timing voices; VOICE_BANK_RELEASE_EN adds one silent beat after each note.
// Latency: a load is visible one cycle after its strobe; a note ends on the edge of its last counted beat.
// Backpressure: done level per voice; strobes to a busy voice are dropped and flagged in sticky load_error.
module voice_bank (
    input  logic         clk,
    input  logic         reset_n,
    voice_bank_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAY    = 2'd1
`ifdef VOICE_BANK_RELEASE_EN
        , ST_RELEASE = 2'd2
`endif
    } state_t;

    logic [2:0] strobe;
    logic [5:0] note_in [3];
    logic [5:0] dur_in  [3];
    logic [2:0] done;
    logic [5:0] vnote   [3];
    logic [2:0] busy_hit;
    logic       counting;
    logic       err_q;

    assign strobe     = {bus.new_note_three, bus.new_note_two, bus.new_note_one};
    assign note_in[0] = bus.note_one;
    assign note_in[1] = bus.note_two;
    assign note_in[2] = bus.note_three;
    assign dur_in[0]  = bus.duration_one;
    assign dur_in[1]  = bus.duration_two;
    assign dur_in[2]  = bus.duration_three;

    // Beats only advance notes while the bank is playing.
    assign counting = bus.play & bus.beat;

    genvar v;
    generate
        for (v = 0; v < 3; v++) begin : g_voice
            state_t     state_q, state_d;
            logic [5:0] note_q, note_d;
            logic [5:0] rem_q, rem_d;
            logic       busy;

            // Voice state, latched note and remaining beat count.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    state_q <= ST_IDLE;
                    note_q  <= '0;
                    rem_q   <= '0;
                end else begin
                    state_q <= state_d;
                    note_q  <= note_d;
                    rem_q   <= rem_d;
                end
            end

            // Next state: load when idle, count beats when playing, flag strobes while busy.
            always_comb begin
                state_d = state_q;
                note_d  = note_q;
                rem_d   = rem_q;
                busy    = 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        // Zero-length notes are dropped silently, not treated as errors.
                        if (strobe[v] && (dur_in[v] != 6'd0)) begin
                            state_d = ST_PLAY;
                            note_d  = note_in[v];
                            rem_d   = dur_in[v];
                        end
                    end
                    ST_PLAY: begin
                        busy = strobe[v];
                        if (counting) begin
                            rem_d = rem_q - 6'd1;
                            if (rem_q == 6'd1) begin
`ifdef VOICE_BANK_RELEASE_EN
                                state_d = ST_RELEASE;
`else
                                state_d = ST_IDLE;
`endif
                            end
                        end
                    end
`ifdef VOICE_BANK_RELEASE_EN
                    ST_RELEASE: begin
                        busy = strobe[v];
                        if (counting) begin
                            state_d = ST_IDLE;
                        end
                    end
`endif
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end

            assign busy_hit[v] = busy;
            assign done[v]     = (state_q == ST_IDLE);
            assign vnote[v]    = ((state_q == ST_PLAY) && bus.play) ? note_q : 6'd0;
        end
    endgenerate

    // Sticky flag: any strobe that landed on a busy voice, held until reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | (|busy_hit);
        end
    end

    assign bus.note_one_done    = done[0];
    assign bus.note_two_done    = done[1];
    assign bus.note_three_done  = done[2];
    assign bus.voice_note_one   = vnote[0];
    assign bus.voice_note_two   = vnote[1];
    assign bus.voice_note_three = vnote[2];
    assign bus.all_idle         = &done;
    assign bus.load_error       = err_q;

endmodule

// File: tb/tb_voice_bank.sv
// Directed and random checks of voice_bank against a beat-counting reference model.
// Latency: model advances on each rising edge; outputs are compared 1 ns later.
// Backpressure: model tracks busy voices and the sticky load error.
module tb_voice_bank;

`ifdef VOICE_BANK_RELEASE_EN
    localparam int REL = 1;
`else
    localparam int REL = 0;
`endif

    logic clk;
    logic reset_n;
    voice_bank_if bus ();

    voice_bank dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: beats still owed by each note, trailing silent beats owed, note code.
    int m_left [3];
    int m_tail [3];
    int m_note [3];
    bit m_err;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic dut_done(input int v);
        case (v)
            0:       return bus.note_one_done;
            1:       return bus.note_two_done;
            default: return bus.note_three_done;
        endcase
    endfunction

    function automatic logic [5:0] dut_note(input int v);
        case (v)
            0:       return bus.voice_note_one;
            1:       return bus.voice_note_two;
            default: return bus.voice_note_three;
        endcase
    endfunction

    function automatic bit m_free(input int v);
        return (m_left[v] == 0) && (m_tail[v] == 0);
    endfunction

    task automatic model_reset();
        for (int v = 0; v < 3; v++) begin
            m_left[v] = 0;
            m_tail[v] = 0;
            m_note[v] = 0;
        end
        m_err = 1'b0;
    endtask

    task automatic model_edge();
        logic [2:0] s;
        int         n [3];
        int         d [3];
        bit         cnt;
        s    = {bus.new_note_three, bus.new_note_two, bus.new_note_one};
        n[0] = bus.note_one;     d[0] = bus.duration_one;
        n[1] = bus.note_two;     d[1] = bus.duration_two;
        n[2] = bus.note_three;   d[2] = bus.duration_three;
        cnt  = bus.play && bus.beat;
        for (int v = 0; v < 3; v++) begin
            if (m_free(v)) begin
                if (s[v] && d[v] != 0) begin
                    m_left[v] = d[v];
                    m_note[v] = n[v];
                end
            end else begin
                if (s[v]) m_err = 1'b1;
                if (cnt) begin
                    if (m_left[v] > 0) begin
                        m_left[v]--;
                        if (m_left[v] == 0) m_tail[v] = REL;
                    end else begin
                        m_tail[v] = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        bit all_free;
        all_free = 1'b1;
        for (int v = 0; v < 3; v++) begin
            chk($sformatf("done%0d", v), {7'd0, dut_done(v)}, {7'd0, m_free(v)});
            chk($sformatf("voice_note%0d", v), {2'd0, dut_note(v)},
                (m_left[v] > 0 && bus.play) ? 8'(m_note[v]) : 8'd0);
            all_free &= m_free(v);
        end
        chk("all_idle", {7'd0, bus.all_idle}, {7'd0, all_free});
        chk("load_error", {7'd0, bus.load_error}, {7'd0, m_err});
    endtask

    task automatic clear_pulses();
        bus.beat           = 1'b0;
        bus.new_note_one   = 1'b0;
        bus.new_note_two   = 1'b0;
        bus.new_note_three = 1'b0;
    endtask

    task automatic load(input int v, input int note, input int dur);
        case (v)
            0: begin bus.new_note_one = 1'b1;   bus.note_one = 6'(note);   bus.duration_one = 6'(dur);   end
            1: begin bus.new_note_two = 1'b1;   bus.note_two = 6'(note);   bus.duration_two = 6'(dur);   end
            default: begin bus.new_note_three = 1'b1; bus.note_three = 6'(note); bus.duration_three = 6'(dur); end
        endcase
    endtask

    // One clock: model follows the edge, outputs compared just after it, pulses dropped.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        clear_pulses();
    endtask

    task automatic beat_tick();
        bus.beat = 1'b1;
        tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && !(m_free(0) && m_free(1) && m_free(2)); i++) begin
            beat_tick();
            tick();
        end
        chk("drain_all_idle", {7'd0, bus.all_idle}, 8'd1);
    endtask

    task automatic check_reset_values(input string tag);
        for (int v = 0; v < 3; v++) begin
            chk({tag, "_done"}, {7'd0, dut_done(v)}, 8'd1);
            chk({tag, "_note"}, {2'd0, dut_note(v)}, 8'd0);
        end
        chk({tag, "_all_idle"}, {7'd0, bus.all_idle}, 8'd1);
        chk({tag, "_load_error"}, {7'd0, bus.load_error}, 8'd0);
    endtask

    initial begin
        reset_n            = 1'b0;
        bus.play           = 1'b1;
        bus.note_one       = '0;
        bus.note_two       = '0;
        bus.note_three     = '0;
        bus.duration_one   = '0;
        bus.duration_two   = '0;
        bus.duration_three = '0;
        clear_pulses();
        model_reset();

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset_n = 1'b1;
        tick();

        // Zero-duration strobe is discarded without an error.
        load(0, 33, 0);
        tick();
        chk("dur0_done", {7'd0, bus.note_one_done}, 8'd1);
        chk("dur0_err", {7'd0, bus.load_error}, 8'd0);

        // Note 20 for 3 beats on voice one.
        load(0, 20, 3);
        tick();
        chk("v1_done_after_load", {7'd0, bus.note_one_done}, 8'd0);
        chk("v1_note", {2'd0, bus.voice_note_one}, 8'd20);
        for (int b = 1; b <= 3 + REL; b++) begin
            tick();
            beat_tick();
            chk($sformatf("v1_done_beat%0d", b), {7'd0, bus.note_one_done},
                (b >= 3 + REL) ? 8'd1 : 8'd0);
        end

        // Voice three: 2 beats, pause across 10 beats, then resume.
        load(2, 45, 4);
        tick();
        beat_tick();
        beat_tick();
        bus.play = 1'b0;
        for (int i = 0; i < 10; i++) begin
            beat_tick();
            chk("v3_paused_note", {2'd0, bus.voice_note_three}, 8'd0);
            chk("v3_paused_done", {7'd0, bus.note_three_done}, 8'd0);
        end
        bus.play = 1'b1;
        tick();
        chk("v3_resumed_note", {2'd0, bus.voice_note_three}, 8'd45);
        beat_tick();
        chk("v3_done_after_3rd", {7'd0, bus.note_three_done}, 8'd0);
        beat_tick();
        chk("v3_done_after_4th", {7'd0, bus.note_three_done}, (REL == 0) ? 8'd1 : 8'd0);
        drain();

        // Simultaneous loads with a coincident beat that must not count.
        load(0, 1, 1);
        load(1, 0, 2);
        load(2, 3, 3);
        bus.beat = 1'b1;
        tick();
        chk("sim_all_busy", {7'd0, bus.all_idle}, 8'd0);
        for (int b = 1; b <= 3 + REL; b++) begin
            beat_tick();
            chk($sformatf("sim_done1_b%0d", b), {7'd0, bus.note_one_done},   (b >= 1 + REL) ? 8'd1 : 8'd0);
            chk($sformatf("sim_done2_b%0d", b), {7'd0, bus.note_two_done},   (b >= 2 + REL) ? 8'd1 : 8'd0);
            chk($sformatf("sim_done3_b%0d", b), {7'd0, bus.note_three_done}, (b >= 3 + REL) ? 8'd1 : 8'd0);
        end
        chk("sim_all_idle", {7'd0, bus.all_idle}, 8'd1);

        // Strobe to busy voice two is ignored and sets the sticky error.
        load(1, 7, 4);
        tick();
        load(1, 9, 5);
        tick();
        chk("busy_keeps_note", {2'd0, bus.voice_note_two}, 8'd7);
        chk("busy_sets_err", {7'd0, bus.load_error}, 8'd1);
        drain();
        chk("err_sticky", {7'd0, bus.load_error}, 8'd1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bus.play = ($urandom_range(0, 9) != 0);
            bus.beat = ($urandom_range(0, 2) == 0);
            for (int v = 0; v < 3; v++) begin
                if ($urandom_range(0, 6) == 0) load(v, int'($urandom_range(0, 63)), int'($urandom_range(0, 6)));
            end
            tick();
        end
        bus.play = 1'b1;

        // Asynchronous reset mid-note clears everything without a clock edge.
        drain();
        load(0, 12, 9);
        load(2, 13, 9);
        tick();
        chk("pre_reset_busy", {7'd0, bus.note_one_done}, 8'd0);
        reset_n = 1'b0;
        #2;
        model_reset();
        check_reset_values("async_reset");
        #3;
        reset_n = 1'b1;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
